// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller:
// RISC-V funct3 width encodings, the controller FSM states, and small
// decode helpers used at request acceptance.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Unsigned widths only exist for loads; everything else is unsupported.
    function automatic logic f3_supported(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Forces the natural alignment of the access width by dropping low bits.
    function automatic logic [31:0] f3_align_addr(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            F3_H, F3_HU: return {addr[31:1], 1'b0};
            F3_W:        return {addr[31:2], 2'b00};
            default:     return addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU: extracts and extends the load
// result from a memory word, and merges store data into a memory word for
// byte/halfword read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  byte_base;
    logic [4:0]  half_base;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_base = {offset, 3'b000};
    assign half_base = {offset[1], 4'b0000};
    assign byte_lane = word[byte_base +: 8];
    assign half_lane = word[half_base +: 16];

    // Load path: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = '0;
        endcase
    end

    // Store path: replace only the addressed lane of the word read back.
    always_comb begin
        store_data = word;
        case (funct3)
            F3_B:    store_data[byte_base +: 8]  = wdata[7:0];
            F3_H:    store_data[half_base +: 16] = wdata[15:0];
            F3_W:    store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller. Accepts one core request at a time,
// performs loads, word stores and byte/halfword read-modify-write stores
// against a synchronous-write / combinational-read data RAM, and returns a
// single-cycle response.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned accesses
// are answered immediately with resp_err=1; otherwise the offending low
// address bits are cleared and the access proceeds.
module lsu_mem_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state;
    state_e      state_nxt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] req_addr_eff;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign accept = (state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err      = !f3_supported(req_we, req_funct3) ||
                          f3_misaligned(req_funct3, req_addr[1:0]);
    assign req_addr_eff = req_addr;
`else
    assign req_err      = !f3_supported(req_we, req_funct3);
    assign req_addr_eff = f3_align_addr(req_funct3, req_addr);
`endif

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (rdata_q),
        .wdata      (wdata_q),
        .load_data  (ld_data),
        .store_data (st_data)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; the reset branch is in the sensitivity list (async).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request capture on acceptance and read-data capture in read states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr_eff;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state == LD_RD || state == RMW_RD) rdata_q <= mem_rd;
        end
    end

    // Next-state and Moore outputs; memory strobes depend on state only so
    // an async reset drops them immediately.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wd     = '0;
        mem_a      = {addr_q[31:2], 2'b00};
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                  state_nxt = RESP;
                    else if (!req_we)             state_nxt = LD_RD;
                    else if (req_funct3 == F3_W)  state_nxt = WR;
                    else                          state_nxt = RMW_RD;
                end
            end
            LD_RD: begin
                mem_re    = 1'b1;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_re    = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_wd    = st_data;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'h0 : ld_data;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
